seq_generator: RTL and testbench

//   Serial pattern transmitter that feeds the sequence detector's bit_i input. It

---
 rtl/seq_generator.sv | 137 +++++++++++++
 tb/tb_seq_generator.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/seq_generator.sv
// Serial pattern transmitter: shifts a latched word out MSB first, rep_i+1 frames back to back,
// then idles for GAP_CYCLES. Define SEQ_GENERATOR_PARITY_EN to append an even-parity bit to each frame.
module seq_generator #(
  parameter int WIDTH      = 4,
  parameter int GAP_CYCLES = 2
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic [3:0]       rep_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic             abort_i,
  output logic             bit_o,
  output logic             bit_vld_o,
  output logic             busy_o,
  output logic             done_o
);

  typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_e;

`ifdef SEQ_GENERATOR_PARITY_EN
  localparam int FLEN = WIDTH + 1;
`else
  localparam int FLEN = WIDTH;
`endif

  localparam logic [4:0] LAST_BIT = 5'(FLEN - 1);
  localparam logic [7:0] GAP_LAST = 8'(GAP_CYCLES - 1);
  localparam bit         HAS_GAP  = (GAP_CYCLES != 0);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] word_q, word_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [4:0]       bit_cnt_q, bit_cnt_d;
  logic [3:0]       rep_cnt_q, rep_cnt_d;
  logic [7:0]       gap_cnt_q, gap_cnt_d;
  logic             bit_d, vld_d, done_d;

  // shreg holds the bits still to be sent after the one currently on bit_o.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    state_d   = state_q;
    word_d    = word_q;
    shreg_d   = shreg_q;
    bit_cnt_d = bit_cnt_q;
    rep_cnt_d = rep_cnt_q;
    gap_cnt_d = gap_cnt_q;
    bit_d     = 1'b0;
    vld_d     = 1'b0;
    done_d    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (valid_i) begin
          state_d   = SHIFT;
          word_d    = data_i;
          rep_cnt_d = rep_i;
          shreg_d   = data_i << 1;
          bit_cnt_d = '0;
          bit_d     = data_i[WIDTH-1];
          vld_d     = 1'b1;
        end
      end

      SHIFT: begin
        if (abort_i) begin
          state_d = IDLE;
        end else if (bit_cnt_q == LAST_BIT) begin
          if (rep_cnt_q != 4'd0) begin
            rep_cnt_d = rep_cnt_q - 4'd1;
            shreg_d   = word_q << 1;
            bit_cnt_d = '0;
            bit_d     = word_q[WIDTH-1];
            vld_d     = 1'b1;
          end else if (HAS_GAP) begin
            state_d   = GAP;
            gap_cnt_d = '0;
          end else begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end else begin
          bit_cnt_d = bit_cnt_q + 5'd1;
          shreg_d   = shreg_q << 1;
          vld_d     = 1'b1;
          bit_d     = shreg_q[WIDTH-1];
`ifdef SEQ_GENERATOR_PARITY_EN
          if (bit_cnt_q == 5'(WIDTH - 1)) bit_d = ^word_q;
`endif
        end
      end

      GAP: begin
        if (abort_i) begin
          state_d = IDLE;
        end else if (gap_cnt_q == GAP_LAST) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          gap_cnt_d = gap_cnt_q + 8'd1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q   <= IDLE;
      word_q    <= '0;
      shreg_q   <= '0;
      bit_cnt_q <= '0;
      rep_cnt_q <= '0;
      gap_cnt_q <= '0;
      bit_o     <= 1'b0;
      bit_vld_o <= 1'b0;
      done_o    <= 1'b0;
    end else begin
      state_q   <= state_d;
      word_q    <= word_d;
      shreg_q   <= shreg_d;
      bit_cnt_q <= bit_cnt_d;
      rep_cnt_q <= rep_cnt_d;
      gap_cnt_q <= gap_cnt_d;
      bit_o     <= bit_d;
      bit_vld_o <= vld_d;
      done_o    <= done_d;
    end
  end

  assign ready_o = (state_q == IDLE);
  assign busy_o  = (state_q != IDLE);

endmodule

// File: tb/tb_seq_generator.sv
// Directed self-checking bench for seq_generator (WIDTH=4, GAP_CYCLES=2), including a
// behavioural 4-bit sequence detector fed from the serial output.
module tb_seq_generator;

  localparam int W   = 4;
  localparam int GAP = 2;
`ifdef SEQ_GENERATOR_PARITY_EN
  localparam int FLEN = W + 1;
`else
  localparam int FLEN = W;
`endif

  logic         clk = 1'b0;
  logic         rstn = 1'b0;
  logic [W-1:0] data_i = '0;
  logic [3:0]   rep_i = '0;
  logic         valid_i = 1'b0;
  logic         abort_i = 1'b0;
  logic         ready_o, bit_o, bit_vld_o, busy_o, done_o;

  int n_cmp = 0;
  int n_err = 0;

  seq_generator #(.WIDTH(W), .GAP_CYCLES(GAP)) dut (
    .clk_i     (clk),
    .rstn_i    (rstn),
    .data_i    (data_i),
    .rep_i     (rep_i),
    .valid_i   (valid_i),
    .ready_o   (ready_o),
    .abort_i   (abort_i),
    .bit_o     (bit_o),
    .bit_vld_o (bit_vld_o),
    .busy_o    (busy_o),
    .done_o    (done_o)
  );

  always #5 clk = ~clk;

  // Loopback detector: flag is high the cycle after the last bit matching REF is shifted in.
  localparam logic [3:0] REF = 4'b1011;
  logic [3:0] hist;
  logic       flag;
  int         flag_cnt = 0;

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      hist <= '0;
      flag <= 1'b0;
    end else begin
      flag <= 1'b0;
      if (bit_vld_o) begin
        hist <= {hist[2:0], bit_o};
        flag <= ({hist[2:0], bit_o} == REF);
      end
    end
  end

  always @(negedge clk) if (flag) flag_cnt++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic exp_bit(input logic [W-1:0] d, input int idx);
    int j = idx % FLEN;
    if (j < W) return d[W-1-j];
    return ^d;
  endfunction

  // Sends one word and checks every cycle through to the done pulse.
  task automatic run_word(input logic [W-1:0] d, input logic [3:0] r, input string tag);
    int frames = int'(r) + 1;
    int busy_cnt = 0;
    @(negedge clk);
    data_i  = d;
    rep_i   = r;
    valid_i = 1'b1;
    @(negedge clk);
    valid_i = 1'b0;
    check({tag, " ready_busy"}, ready_o, 1'b0);
    for (int i = 0; i < frames * FLEN; i++) begin
      check($sformatf("%s bit%0d", tag, i), bit_o, exp_bit(d, i));
      check($sformatf("%s vld%0d", tag, i), bit_vld_o, 1'b1);
      if (busy_o) busy_cnt++;
      @(negedge clk);
    end
    for (int g = 0; g < GAP; g++) begin
      check($sformatf("%s gap_vld%0d", tag, g), bit_vld_o, 1'b0);
      check($sformatf("%s gap_bit%0d", tag, g), bit_o, 1'b0);
      if (busy_o) busy_cnt++;
      @(negedge clk);
    end
    check({tag, " done"}, done_o, 1'b1);
    check({tag, " ready_end"}, ready_o, 1'b1);
    check({tag, " busy_cycles"}, busy_cnt, frames * FLEN + GAP);
    @(negedge clk);
    check({tag, " done_pulse"}, done_o, 1'b0);
  endtask

  initial begin
    int seen_done;
    #12;
    check("rst ready", ready_o, 1'b1);
    check("rst bit", bit_o, 1'b0);
    check("rst vld", bit_vld_o, 1'b0);
    check("rst busy", busy_o, 1'b0);
    check("rst done", done_o, 1'b0);
    @(negedge clk);
    rstn = 1'b1;

    // Single frame, then loopback with three frames.
    run_word(4'b1011, 4'd0, "t1");
    flag_cnt = 0;
    run_word(4'b1011, 4'd2, "t2");
    check("t2 flags", flag_cnt, 3);

    // Back-to-back frames, then the 16-frame maximum.
    run_word(4'b0110, 4'd1, "t3");
    run_word(4'b1001, 4'd15, "t3max");

    // valid_i held high while busy: the second word is only taken at the done cycle.
    @(negedge clk);
    data_i  = 4'b0010;
    rep_i   = 4'd0;
    valid_i = 1'b1;
    @(negedge clk);
    data_i = 4'hF;
    for (int i = 0; i < FLEN; i++) begin
      check($sformatf("t4 bit%0d", i), bit_o, exp_bit(4'b0010, i));
      @(negedge clk);
    end
    for (int g = 0; g < GAP; g++) begin
      check($sformatf("t4 gap%0d", g), bit_vld_o, 1'b0);
      @(negedge clk);
    end
    check("t4 done", done_o, 1'b1);
    @(negedge clk);
    valid_i = 1'b0;
    check("t4 second_msb", bit_o, 1'b1);
    check("t4 second_vld", bit_vld_o, 1'b1);
    seen_done = 0;
    for (int i = 0; i < 40 && seen_done == 0; i++) begin
      @(negedge clk);
      if (done_o) seen_done = 1;
    end
    check("t4 second_done", seen_done, 1);

    // abort_i in IDLE has no effect.
    @(negedge clk);
    abort_i = 1'b1;
    @(negedge clk);
    abort_i = 1'b0;
    check("t5 idle_abort_ready", ready_o, 1'b1);

    // abort_i on the second bit of a frame.
    data_i  = 4'b1011;
    rep_i   = 4'd1;
    valid_i = 1'b1;
    @(negedge clk);
    valid_i = 1'b0;
    @(negedge clk);
    check("t5 second_bit", bit_o, 1'b0);
    abort_i = 1'b1;
    @(negedge clk);
    abort_i = 1'b0;
    check("t5 abort_vld", bit_vld_o, 1'b0);
    check("t5 abort_ready", ready_o, 1'b1);
    check("t5 abort_done", done_o, 1'b0);
    seen_done = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done_o) seen_done = 1;
    end
    check("t5 no_done_after_abort", seen_done, 0);

    // Asynchronous reset in the middle of a frame.
    data_i  = 4'b1111;
    rep_i   = 4'd3;
    valid_i = 1'b1;
    @(negedge clk);
    valid_i = 1'b0;
    @(negedge clk);
    #2 rstn = 1'b0;
    #1;
    check("t5 rst_bit", bit_o, 1'b0);
    check("t5 rst_vld", bit_vld_o, 1'b0);
    check("t5 rst_busy", busy_o, 1'b0);
    check("t5 rst_ready", ready_o, 1'b1);
    @(negedge clk);
    rstn = 1'b1;
    seen_done = 0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (done_o) seen_done = 1;
    end
    check("t5 no_done_after_rst", seen_done, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
